// File: rtl/nabp_image_ram_sequencer_pkg.sv
// Shared definitions for the image RAM sequencer: sequencer states and the
// address/pass-counter width helpers shared with the image addresser.
package nabp_image_ram_sequencer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CLEAR,
        SEQ_KICK,
        SEQ_WAIT_START,
        SEQ_STREAM,
        SEQ_DONE
    } seq_state_t;

    // Default geometry of a reconstruction run
    localparam int kDefaultImageSize  = 32;
    localparam int kDefaultNoOfPasses = 4;

    // Width of an image RAM address for an N x N image (at least one bit)
    function automatic int image_addr_width(input int image_size);
        int depth;
        depth = image_size * image_size;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold the values 0..passes inclusive
    function automatic int pass_count_width(input int passes);
        return (passes > 0) ? $clog2(passes + 1) : 1;
    endfunction

    // Widths at the default geometry, matching the image addresser
    localparam int kDefaultImageAddressLength = image_addr_width(kDefaultImageSize);
    localparam int kDefaultPassCountLength    = pass_count_width(kDefaultNoOfPasses);

endpackage

// File: rtl/nabp_image_ram_sequencer_ram_port_mux.sv
// Image RAM port selection: picks address, write enable and clear flag from
// the clear sweep, the addresser stream or the host readout, keyed by state.
module nabp_ram_port_mux
    import nabp_image_ram_sequencer_pkg::*;
#(
    parameter int kImageAddressLength = kDefaultImageAddressLength
) (
    input  seq_state_t                     state,
    input  logic [kImageAddressLength-1:0] clear_addr,
    input  logic [kImageAddressLength-1:0] ad_ir_addr,
    input  logic [kImageAddressLength-1:0] hr_addr,
    input  logic                           pe_valid,
    output logic [kImageAddressLength-1:0] ir_addr,
    output logic                           ir_we,
    output logic                           ir_clear
);

    // Route the RAM port; states with no RAM traffic park the address at zero
    always_comb begin
        ir_addr  = '0;
        ir_we    = 1'b0;
        ir_clear = 1'b0;
        case (state)
            SEQ_IDLE: begin
                ir_addr = hr_addr;
            end
            SEQ_CLEAR: begin
                ir_addr  = clear_addr;
                ir_we    = 1'b1;
                ir_clear = 1'b1;
            end
            SEQ_STREAM: begin
                ir_addr = ad_ir_addr;
                ir_we   = pe_valid;
            end
            default: begin
                ir_addr  = '0;
                ir_we    = 1'b0;
                ir_clear = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nabp_image_ram_sequencer.sv
// Image RAM run controller: zeroes the image RAM on a host kick, then drives
// a fixed number of back-projection passes through the image addresser,
// and hands the RAM port to host readout whenever it is idle.
module nabp_image_ram_sequencer
    import nabp_image_ram_sequencer_pkg::*;
#(
    parameter int kImageSize          = kDefaultImageSize,
    parameter int kNoOfPasses         = kDefaultNoOfPasses,
    parameter int kImageAddressLength = image_addr_width(kImageSize),
    parameter int kPassCountLength    = pass_count_width(kNoOfPasses)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hs_kick,
    output logic                           hs_busy,
    output logic                           hs_done,
    output logic                           hr_grant,
    input  logic [kImageAddressLength-1:0] hr_addr,
    output logic                           ad_kick,
    input  logic                           ad_ir_kick,
    input  logic                           ad_ir_done,
    input  logic [kImageAddressLength-1:0] ad_ir_addr,
    output logic                           ad_ir_enable,
    input  logic                           pe_valid,
    output logic [kImageAddressLength-1:0] ir_addr,
    output logic                           ir_we,
    output logic                           ir_clear
);

    localparam logic [kImageAddressLength-1:0] kLastAddr =
        kImageAddressLength'(kImageSize * kImageSize - 1);
    localparam logic [kPassCountLength-1:0] kPassTarget =
        kPassCountLength'(kNoOfPasses);

    seq_state_t                     state_q;
    seq_state_t                     state_d;
    logic [kImageAddressLength-1:0] clear_addr_q;
    logic [kPassCountLength-1:0]    pass_cnt_q;
    logic [kPassCountLength-1:0]    pass_cnt_inc;
    logic                           pass_end;

    // A pass ends only on an addresser done that coincides with a valid sample
    always_comb begin
        pass_cnt_inc = pass_cnt_q + kPassCountLength'(1);
        pass_end     = (state_q == SEQ_STREAM) && pe_valid && ad_ir_done;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kicks and addresser strobes outside their states are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE: begin
                if (hs_kick) begin
                    state_d = SEQ_CLEAR;
                end
            end
            SEQ_CLEAR: begin
                if (clear_addr_q == kLastAddr) begin
                    state_d = SEQ_KICK;
                end
            end
            SEQ_KICK: begin
                state_d = SEQ_WAIT_START;
            end
            SEQ_WAIT_START: begin
                if (ad_ir_kick) begin
                    state_d = SEQ_STREAM;
                end
            end
            SEQ_STREAM: begin
                if (pass_end) begin
                    state_d = (pass_cnt_inc == kPassTarget) ? SEQ_DONE : SEQ_KICK;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Clear sweep address: restarts on a new run and stops at the last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_addr_q <= '0;
        end else if (state_q == SEQ_IDLE && hs_kick) begin
            clear_addr_q <= '0;
        end else if (state_q == SEQ_CLEAR && clear_addr_q != kLastAddr) begin
            clear_addr_q <= clear_addr_q + kImageAddressLength'(1);
        end
    end

    // Completed-pass counter: restarts on a new run, counts qualified done strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt_q <= '0;
        end else if (state_q == SEQ_IDLE && hs_kick) begin
            pass_cnt_q <= '0;
        end else if (pass_end) begin
            pass_cnt_q <= pass_cnt_inc;
        end
    end

    // Host and addresser handshakes decoded straight from the state
    always_comb begin
        hs_busy      = (state_q != SEQ_IDLE);
        hr_grant     = (state_q == SEQ_IDLE);
        hs_done      = (state_q == SEQ_DONE);
        ad_kick      = (state_q == SEQ_KICK);
        ad_ir_enable = (state_q == SEQ_STREAM) && pe_valid;
    end

    nabp_ram_port_mux #(
        .kImageAddressLength(kImageAddressLength)
    ) u_port_mux (
        .state      (state_q),
        .clear_addr (clear_addr_q),
        .ad_ir_addr (ad_ir_addr),
        .hr_addr    (hr_addr),
        .pe_valid   (pe_valid),
        .ir_addr    (ir_addr),
        .ir_we      (ir_we),
        .ir_clear   (ir_clear)
    );

endmodule

// File: tb/tb_nabp_image_ram_sequencer.sv
// Testbench for nabp_image_ram_sequencer at N=4, two passes, with the bench
// acting as the image addresser and the PE chain.
module tb_nabp_image_ram_sequencer;

    localparam int kN      = 4;
    localparam int kPasses = 2;
    localparam int kDepth  = kN * kN;
    localparam int kAw     = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           hs_kick;
    logic           hs_busy;
    logic           hs_done;
    logic           hr_grant;
    logic [kAw-1:0] hr_addr;
    logic           ad_kick;
    logic           ad_ir_kick;
    logic           ad_ir_done;
    logic [kAw-1:0] ad_ir_addr;
    logic           ad_ir_enable;
    logic           pe_valid;
    logic [kAw-1:0] ir_addr;
    logic           ir_we;
    logic           ir_clear;

    int vectors     = 0;
    int miscompares = 0;

    nabp_image_ram_sequencer #(
        .kImageSize (kN),
        .kNoOfPasses(kPasses)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hs_kick     (hs_kick),
        .hs_busy     (hs_busy),
        .hs_done     (hs_done),
        .hr_grant    (hr_grant),
        .hr_addr     (hr_addr),
        .ad_kick     (ad_kick),
        .ad_ir_kick  (ad_ir_kick),
        .ad_ir_done  (ad_ir_done),
        .ad_ir_addr  (ad_ir_addr),
        .ad_ir_enable(ad_ir_enable),
        .pe_valid    (pe_valid),
        .ir_addr     (ir_addr),
        .ir_we       (ir_we),
        .ir_clear    (ir_clear)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [kAw-1:0] observed,
                            input logic [kAw-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expBusy, input logic expDone,
                               input logic expGrant, input logic expAdKick,
                               input logic expEnable, input logic expWe,
                               input logic expClear, input logic [kAw-1:0] expAddr);
        checkOne({tag, ".hs_busy"},      {3'b0, hs_busy},      {3'b0, expBusy});
        checkOne({tag, ".hs_done"},      {3'b0, hs_done},      {3'b0, expDone});
        checkOne({tag, ".hr_grant"},     {3'b0, hr_grant},     {3'b0, expGrant});
        checkOne({tag, ".ad_kick"},      {3'b0, ad_kick},      {3'b0, expAdKick});
        checkOne({tag, ".ad_ir_enable"}, {3'b0, ad_ir_enable}, {3'b0, expEnable});
        checkOne({tag, ".ir_we"},        {3'b0, ir_we},        {3'b0, expWe});
        checkOne({tag, ".ir_clear"},     {3'b0, ir_clear},     {3'b0, expClear});
        checkOne({tag, ".ir_addr"},      ir_addr,              expAddr);
    endtask

    task automatic applyStimulus(input logic kick, input logic irKick, input logic irDone,
                                 input logic [kAw-1:0] irAddr, input logic peValid,
                                 input logic [kAw-1:0] hrAddr);
        hs_kick    = kick;
        ad_ir_kick = irKick;
        ad_ir_done = irDone;
        ad_ir_addr = irAddr;
        pe_valid   = peValid;
        hr_addr    = hrAddr;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [kAw-1:0] rnd4();
        return kAw'($urandom);
    endfunction

    // One reconstruction run, starting in an idle cycle. holdKick keeps hs_kick
    // high throughout; abortAt >= 0 asserts reset after that many stream cycles
    // of the first pass, then checks the block stays quiet in idle.
    task automatic doRun(input bit holdKick, input bit directedPe, input int abortAt);
        logic [kAw-1:0] hr;
        logic [kAw-1:0] addrs [8];
        logic           pe;
        logic           done;
        int             len;
        int             idx;
        int             waits;
        int             streamCycles;
        bit             finished;

        hr = rnd4();
        applyStimulus(1'b1, 1'b0, $urandom_range(0, 1) == 1, rnd4(), 1'b0, hr);
        checkOutput("kick_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hr);
        nextCycle();

        for (int i = 0; i < kDepth; i++) begin
            applyStimulus(holdKick, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          rnd4(), $urandom_range(0, 1) == 1, rnd4());
            checkOutput($sformatf("clear%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b1, kAw'(i));
            nextCycle();
        end

        for (int p = 0; p < kPasses; p++) begin
            applyStimulus(holdKick, 1'b0, 1'b0, rnd4(), $urandom_range(0, 1) == 1, rnd4());
            checkOutput($sformatf("kick_p%0d", p), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                        1'b0, 1'b0, '0);
            nextCycle();

            waits = $urandom_range(0, 3);
            for (int w = 0; w <= waits; w++) begin
                applyStimulus(holdKick, w == waits, $urandom_range(0, 1) == 1, rnd4(),
                              $urandom_range(0, 1) == 1, rnd4());
                checkOutput($sformatf("wait_p%0d", p), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, '0);
                nextCycle();
            end

            len = $urandom_range(2, 5);
            for (int k = 0; k < len; k++) addrs[k] = rnd4();
            idx          = 0;
            streamCycles = 0;
            finished     = 1'b0;
            while (!finished && streamCycles < 200) begin
                if (directedPe && p == 0 && streamCycles < 3) begin
                    pe = (streamCycles != 1);
                end else begin
                    pe = ($urandom_range(0, 1) == 1);
                end
                done = (idx == len - 1);
                applyStimulus(holdKick, 1'b0, done, addrs[idx], pe, rnd4());
                checkOutput($sformatf("stream_p%0d", p), 1'b1, 1'b0, 1'b0, 1'b0, pe,
                            pe, 1'b0, addrs[idx]);
                if (abortAt >= 0 && p == 0 && streamCycles == abortAt) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    checkOutput("abort_async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, hr_addr);
                    nextCycle();
                    checkOutput("abort_held", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, hr_addr);
                    reset = 1'b0;
                    for (int q = 0; q < 4; q++) begin
                        hr = rnd4();
                        applyStimulus(1'b0, 1'b1, 1'b1, rnd4(), 1'b1, hr);
                        checkOutput("abort_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                    1'b0, hr);
                        nextCycle();
                    end
                    return;
                end
                nextCycle();
                streamCycles++;
                if (pe) begin
                    if (done) finished = 1'b1;
                    else      idx++;
                end
            end
            if (!finished) begin
                checkOne("stream_bound", 4'd1, 4'd0);
            end
        end

        applyStimulus(holdKick, 1'b0, 1'b1, rnd4(), 1'b1, rnd4());
        checkOutput("done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        nextCycle();
    endtask

    // Directed sequence of runs with randomised data and handshake timing
    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd5);
        checkOutput("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1 & 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 4'd5);
        checkOutput("idle_hr5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        nextCycle();

        $display("[TB] run 1: hs_kick held high for the whole run");
        doRun(1'b1, 1'b1, -1);
        $display("[TB] run 2: kick in the cycle after hs_done");
        doRun(1'b0, 1'b0, -1);
        $display("[TB] run 3: reset during the first stream");
        doRun(1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
